// File: rtl/uart_pkg.sv
// Shared UART definitions: common character width and the FIFO status
// bundle consumed by the CSR block.
package uart_pkg;

  // Character width shared by the receiver, transmitter and their FIFOs.
  localparam int unsigned UartDataWidth  = 8;

  // Default FIFO depth, and the count width that goes with it.
  localparam int unsigned UartFifoDepth  = 16;
  localparam int unsigned UartFifoCountW = $clog2(UartFifoDepth + 1);

  // Status bundle exported to software through the CSR block.
  typedef struct packed {
    logic [UartFifoCountW-1:0] count;
    logic                      empty;
    logic                      full;
    logic                      almost_full;
    logic                      overrun;
  } uart_fifo_status_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// Depth x DataWidth register array: one synchronous write port, one
// asynchronous read port. Storage is deliberately not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth = UartDataWidth,
  parameter int unsigned Depth     = UartFifoDepth,
  localparam int unsigned AddrW    = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrW-1:0]     wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [AddrW-1:0]     rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [Depth-1:0][DataWidth-1:0] entries;

  for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
    logic [DataWidth-1:0] entry_reg;

    // Capture the write data when this entry is the write target.
    always_ff @(posedge clk_i) begin
      if (wr_en_i && (wr_addr_i == AddrW'(gi))) begin
        entry_reg <= wr_data_i;
      end
    end

    assign entries[gi] = entry_reg;
  end

  // Show-ahead read: combinational mux on the read address.
  assign rd_data_o = entries[rd_addr_i];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: captures data-valid pulses,
// presents a show-ahead valid/ready read port and reports fill status.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DataWidth       = UartDataWidth,
  parameter int unsigned Depth           = 16,
  parameter int unsigned AlmostFullLevel = 12,
  localparam int unsigned IdxW           = $clog2(Depth),
  localparam int unsigned PtrW           = IdxW + 1,
  localparam int unsigned CountW         = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_dv_i,
  input  logic [DataWidth-1:0] rx_data_i,
  output logic                 rd_valid_o,
  input  logic                 rd_ready_i,
  output logic [DataWidth-1:0] rd_data_o,
  input  logic                 flush_i,
  input  logic                 overrun_clr_i,
  output logic [CountW-1:0]    count_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic                 overrun_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic            overrun_reg, overrun_next;
  logic            empty, full, push, pop, drop;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[IdxW-1:0] == rd_ptr_reg[IdxW-1:0]) &&
                 (wr_ptr_reg[IdxW] != rd_ptr_reg[IdxW]);

  // A pop while full frees the slot the simultaneous push needs.
  assign pop  = !empty && rd_ready_i;
  assign push = rx_dv_i && (!full || pop);
  // A character lost to a full FIFO; a flush drops it silently instead.
  assign drop = rx_dv_i && full && !pop && !flush_i;

  // Next-state for pointers and the sticky overrun flag; flush wins over traffic.
  always_comb begin
    wr_ptr_next  = wr_ptr_reg;
    rd_ptr_next  = rd_ptr_reg;
    overrun_next = overrun_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + PtrW'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PtrW'(1);
    end
    if (overrun_clr_i) overrun_next = 1'b0;
    if (drop)          overrun_next = 1'b1;
  end

  // Pointer and flag registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      wr_ptr_reg  <= wr_ptr_next;
      rd_ptr_reg  <= rd_ptr_next;
      overrun_reg <= overrun_next;
    end
  end

  uart_fifo_mem #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (push && !flush_i),
    .wr_addr_i (wr_ptr_reg[IdxW-1:0]),
    .wr_data_i (rx_data_i),
    .rd_addr_i (rd_ptr_reg[IdxW-1:0]),
    .rd_data_o (rd_data_o)
  );

  // Status derives only from registered pointers and the overrun register.
  assign count_o       = CountW'(wr_ptr_reg - rd_ptr_reg);
  assign empty_o       = empty;
  assign full_o        = full;
  assign almost_full_o = (count_o >= CountW'(AlmostFullLevel));
  assign overrun_o     = overrun_reg;
  assign rd_valid_o    = !empty;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with hand-computed expectations.
module tb_uart_rx_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       rx_dv_i;
  logic [7:0] rx_data_i;
  logic       rd_valid_o;
  logic       rd_ready_i;
  logic [7:0] rd_data_o;
  logic       flush_i;
  logic       overrun_clr_i;
  logic [4:0] count_o;
  logic       empty_o;
  logic       full_o;
  logic       almost_full_o;
  logic       overrun_o;

  int check_count = 0;
  int pass_count  = 0;

  uart_rx_fifo #(
    .DataWidth       (8),
    .Depth           (16),
    .AlmostFullLevel (12)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rx_dv_i       (rx_dv_i),
    .rx_data_i     (rx_data_i),
    .rd_valid_o    (rd_valid_o),
    .rd_ready_i    (rd_ready_i),
    .rd_data_o     (rd_data_o),
    .flush_i       (flush_i),
    .overrun_clr_i (overrun_clr_i),
    .count_o       (count_o),
    .empty_o       (empty_o),
    .full_o        (full_o),
    .almost_full_o (almost_full_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
      $display("ok   %-16s got=0x%0h", tag, got);
    end else begin
      $display("FAIL %-16s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    rx_dv_i   = 1'b1;
    rx_data_i = d;
    step();
    rx_dv_i   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(count_o), 32'd0);
    check({tag, "_empty"}, 32'(empty_o), 32'd1);
    check({tag, "_full"},  32'(full_o), 32'd0);
    check({tag, "_afull"}, 32'(almost_full_o), 32'd0);
    check({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
    check({tag, "_ovr"},   32'(overrun_o), 32'd0);
  endtask

  initial begin
    rst_ni        = 1'b0;
    rx_dv_i       = 1'b0;
    rx_data_i     = 8'h00;
    rd_ready_i    = 1'b0;
    flush_i       = 1'b0;
    overrun_clr_i = 1'b0;
    #2;
    check_reset_state("rst");
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Two pushes, then one pop.
    push_byte(8'h41);
    push_byte(8'h42);
    check("t1_count", 32'(count_o), 32'd2);
    check("t1_valid", 32'(rd_valid_o), 32'd1);
    check("t1_head", 32'(rd_data_o), 32'h41);
    rd_ready_i = 1'b1;
    step();
    check("t1_head2", 32'(rd_data_o), 32'h42);
    check("t1_count2", 32'(count_o), 32'd1);
    step();
    check("t1_empty", 32'(empty_o), 32'd1);
    // Read while empty is ignored.
    step();
    check("t1_noundf_cnt", 32'(count_o), 32'd0);
    check("t1_noundf_val", 32'(rd_valid_o), 32'd0);
    rd_ready_i = 1'b0;

    // Fill to 16, almost-full at 12, then overrun.
    for (int i = 0; i < 16; i++) begin
      push_byte(8'(i));
      if (i == 10) check("t2_afull_11", 32'(almost_full_o), 32'd0);
      if (i == 11) check("t2_afull_12", 32'(almost_full_o), 32'd1);
      if (i == 14) check("t2_full_15", 32'(full_o), 32'd0);
    end
    check("t2_full_16", 32'(full_o), 32'd1);
    check("t2_count16", 32'(count_o), 32'd16);
    check("t2_ovr_pre", 32'(overrun_o), 32'd0);
    push_byte(8'hAA);
    check("t2_ovr", 32'(overrun_o), 32'd1);
    check("t2_count_ovr", 32'(count_o), 32'd16);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_rd%0d", i), 32'(rd_data_o), 32'(i));
      step();
    end
    rd_ready_i = 1'b0;
    check("t2_drained", 32'(empty_o), 32'd1);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("t2_ovr_clr", 32'(overrun_o), 32'd0);

    // Push and pop together while full.
    for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
    rd_ready_i = 1'b1;
    push_byte(8'h55);
    rd_ready_i = 1'b0;
    check("t3_ovr", 32'(overrun_o), 32'd0);
    check("t3_count", 32'(count_o), 32'd16);
    check("t3_full", 32'(full_o), 32'd1);
    rd_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_rd%0d", i), 32'(rd_data_o), (i == 15) ? 32'h55 : 32'(8'h11 + 8'(i)));
      step();
    end
    rd_ready_i = 1'b0;
    check("t3_empty", 32'(empty_o), 32'd1);

    // Streaming 40 bytes, pointers wrap.
    rx_dv_i   = 1'b1;
    rx_data_i = 8'h80;
    step();
    for (int k = 1; k < 40; k++) begin
      rx_data_i  = 8'h80 + 8'(k);
      rd_ready_i = 1'b1;
      check($sformatf("t4_rd%0d", k - 1), 32'(rd_data_o), 32'(8'h80 + 8'(k - 1)));
      step();
      check($sformatf("t4_cnt%0d", k), 32'(count_o), 32'd1);
    end
    rx_dv_i = 1'b0;
    check("t4_rd39", 32'(rd_data_o), 32'hA7);
    step();
    rd_ready_i = 1'b0;
    check("t4_empty", 32'(empty_o), 32'd1);

    // Overrun set wins over clear in the same cycle.
    for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
    push_byte(8'hEE);
    check("t5_ovr_set", 32'(overrun_o), 32'd1);
    overrun_clr_i = 1'b1;
    push_byte(8'hEF);
    overrun_clr_i = 1'b0;
    check("t5_set_wins", 32'(overrun_o), 32'd1);

    // Flush while full with an incoming byte: overrun kept, no new one.
    flush_i = 1'b1;
    push_byte(8'hF0);
    flush_i = 1'b0;
    check("t6_flush_cnt", 32'(count_o), 32'd0);
    check("t6_flush_ovr", 32'(overrun_o), 32'd1);
    for (int i = 0; i < 5; i++) push_byte(8'h30 + 8'(i));
    check("t6_cnt5", 32'(count_o), 32'd5);
    flush_i = 1'b1;
    push_byte(8'h77);
    flush_i = 1'b0;
    check("t6_cnt0", 32'(count_o), 32'd0);
    check("t6_empty", 32'(empty_o), 32'd1);
    check("t6_valid", 32'(rd_valid_o), 32'd0);
    check("t6_ovr_keep", 32'(overrun_o), 32'd1);
    overrun_clr_i = 1'b1;
    step();
    overrun_clr_i = 1'b0;
    check("t5_clr_alone", 32'(overrun_o), 32'd0);

    // Flush beats overrun when full.
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    flush_i = 1'b1;
    push_byte(8'h66);
    flush_i = 1'b0;
    check("t6_fl_noovr", 32'(overrun_o), 32'd0);
    check("t6_fl_cnt", 32'(count_o), 32'd0);
    push_byte(8'h3C);
    check("t6_after_head", 32'(rd_data_o), 32'h3C);
    check("t6_after_cnt", 32'(count_o), 32'd1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 5; i++) push_byte(8'h50 + 8'(i));
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'h00);
    check("t7_pre_afull", 32'(almost_full_o), 32'd1);
    push_byte(8'h00);
    push_byte(8'h00);
    push_byte(8'hEE);
    check("t7_pre_ovr", 32'(overrun_o), 32'd1);
    #3;
    rst_ni = 1'b0;
    #1;
    check_reset_state("t7_async");
    #2;
    rst_ni = 1'b1;
    step();
    push_byte(8'h99);
    check("t7_first_head", 32'(rd_data_o), 32'h99);
    check("t7_first_cnt", 32'(count_o), 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive buffer directly downstream of the UART receiver.
- Captures each byte the receiver presents with its one-cycle data-valid pulse.
- Holds up to Depth bytes and hands them to the bus/CPU side over a show-ahead valid/ready read port.
- Reports fill level, almost-full and a sticky overrun flag so software can detect lost characters.

Parameters:
DataWidth, 8, width of one received character (matches receiver data width)
Depth, 16, number of entries; power of two, >= 2
AlmostFullLevel, 12, almost_full_o asserts when count >= this value; range 1..Depth

Ports:
clk_i  input  1  system clock
rst_ni  input  1  asynchronous active-low reset
rx_dv_i  input  1  receiver data-valid; single-cycle pulse per character
rx_data_i  input  DataWidth  receiver character; sampled only when rx_dv_i=1
rd_valid_o  output  1  head entry available (= !empty)
rd_ready_i  input  1  consumer accepts head entry this cycle
rd_data_o  output  DataWidth  head entry; valid while rd_valid_o=1
flush_i  input  1  synchronous clear of all stored entries
overrun_clr_i  input  1  clears sticky overrun flag
count_o  output  $clog2(Depth+1)  current number of stored entries
empty_o  output  1  count_o == 0
full_o  output  1  count_o == Depth
almost_full_o  output  1  count_o >= AlmostFullLevel
overrun_o  output  1  sticky: a character was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. All state is cleared on rst_ni=0 regardless of the clock.
- Reset values: pointers=0, count_o=0, empty_o=1, full_o=0, almost_full_o=0, rd_valid_o=0, overrun_o=0. rd_data_o is don't-care while empty. Storage array is not reset.
- Pointers: write and read pointers are $clog2(Depth)+1 bits wide. Index = low bits. Full = indices equal and MSBs differ; empty = pointers equal. Wrap-around is natural modulo 2*Depth.
- Push: rx_dv_i=1 and (not full, or pop this cycle). Data is written at the write index; the write pointer increments at the clock edge.
- Pop: rd_valid_o=1 and rd_ready_i=1. The read pointer increments at the clock edge.
- Read port: show-ahead. rd_data_o is a combinational read of the entry at the read index. A pushed byte appears on rd_data_o / rd_valid_o one cycle after its rx_dv_i pulse; write-to-read latency is 1 cycle.
- Simultaneous push and pop:
  - Non-empty: count unchanged; both pointers advance.
  - Empty: no pop occurs (rd_valid_o=0); push proceeds.
  - Full: the pop frees a slot and the push is accepted; no overrun.
- Overrun: rx_dv_i=1 while full with no pop in the same cycle. The character is discarded, storage and pointers are unchanged, and overrun_o is set next cycle.
- overrun_o stays high until overrun_clr_i=1. If clear and a new overrun occur in the same cycle, set wins.
- rd_ready_i while empty is ignored; no underflow and no pointer movement.
- count_o, empty_o, full_o and almost_full_o are registered or derived from registered pointers only, with no combinational path from inputs. They reflect the state after the previous edge.
- Flush: flush_i=1 sets both pointers to 0 at the next edge.
  - Flush has priority over push and pop in the same cycle; the incoming character is dropped and no overrun is flagged.
  - Flush does not clear overrun_o.
- Reset mid-operation: all entries are lost and flags clear immediately (asynchronously). The first rx_dv_i after rst_ni deasserts lands at index 0.
- No state machine is required beyond the pointer/flag registers. The block must tolerate rx_dv_i pulses on consecutive cycles (each is a separate push).

Decomposition:
- Shared package uart_pkg holds:
  - the common DataWidth default constant, shared with the receiver and transmitter;
  - a typedef for the FIFO status bundle (count, empty, full, almost_full, overrun), reused by the CSR block.
- One sub-module is natural: uart_fifo_mem. It is a Depth x DataWidth register array with one synchronous write port and one asynchronous read port, no reset on storage. It is reused later by the TX FIFO.

Test Plan:
- After reset, push 0x41 then 0x42 on cycles 0 and 1 with rd_ready_i=0 -> cycle 2: count_o=2, rd_valid_o=1, rd_data_o=0x41; assert rd_ready_i for 1 cycle -> rd_data_o=0x42, count_o=1.
- Push 16 bytes 0x00..0x0F -> almost_full_o rises when count_o reaches 12, full_o=1 at 16; push 0xAA with rd_ready_i=0 -> overrun_o=1, count_o stays 16, subsequent reads return 0x00..0x0F (0xAA absent).
- With FIFO full, push 0x55 and pop in the same cycle -> no overrun, count_o=16, the 16th read returns 0x55.
- Push/pop 40 bytes streaming (push and pop every cycle after the first) -> pointers wrap twice, read sequence matches write sequence exactly, count_o holds at 1.
- Set overrun, then assert overrun_clr_i in the same cycle as a fresh overrun -> overrun_o remains 1; next cycle clear alone -> 0.
- Fill with 5 bytes, assert flush_i together with rx_dv_i (0x77) -> next cycle count_o=0, empty_o=1, overrun_o unchanged.
- Repeat with 5 bytes, assert rst_ni=0 asynchronously between clock edges -> all outputs return to reset values immediately.
